sram_bf_rmw: RTL and testbench
==============================

Name: sram_bf_rmw

Overview:
- Bloom-filter read-modify-write client that sits directly upstream of the SRAM arbiter's wr/rd requester port.
- Accepts one INSERT or QUERY command per transaction: 19-bit word address plus 72-bit bit-mask.
- QUERY: reads the word and reports whether all mask bits are set.
- INSERT: reads the word, ORs in the mask and writes it back; the write is skipped when the bits are already present.

Parameters:
- SRAM_ADDR_WIDTH, 19, word address width
- SRAM_DATA_WIDTH, 72, SRAM word width (both banks)
- RD_TIMEOUT, 15, max cycles from rd_ack to rd_vld before error
- CNT_WIDTH, 32, statistics counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, accepts command this cycle
- cmd_insert  in  1  1 = INSERT, 0 = QUERY
- cmd_addr  in  SRAM_ADDR_WIDTH  word address
- cmd_mask  in  SRAM_DATA_WIDTH  bit-mask to test/set
- res_valid  out  1  one-cycle result pulse
- res_hit  out  1  all mask bits were already set (before any write)
- res_err  out  1  read timed out; command aborted
- wr_req  out  1  write request pulse to arbiter
- wr_addr  out  SRAM_ADDR_WIDTH  write address
- wr_data  out  SRAM_DATA_WIDTH  write data
- wr_ack  in  1  arbiter accepted write (registered, cycle after wr_req)
- rd_req  out  1  read request pulse to arbiter
- rd_addr  out  SRAM_ADDR_WIDTH  read address
- rd_ack  in  1  arbiter accepted read (cycle after rd_req)
- rd_vld  in  1  rd_data valid
- rd_data  in  SRAM_DATA_WIDTH  read word
- cnt_insert, cnt_query, cnt_hit  out  CNT_WIDTH  statistics counters (wrap at 2^CNT_WIDTH, no saturation)

Behaviour:
- Reset values: state IDLE; cmd_ready 1; res_valid, res_hit, res_err, wr_req, rd_req 0; addr/data/mask regs 0; counters 0.
- Reset mid-transaction: the request is abandoned with no result pulse. A rd_vld that arrives after reset is ignored because the block is in IDLE.
- Request protocol: the arbiter latches a request the same cycle it sees it and acks one cycle later. If req were held high through the ack cycle, the arbiter would issue a duplicate access. Therefore:
  - rd_req/wr_req are driven as single-cycle pulses.
  - The cycle after a pulse, req is 0 and the ack is sampled.
  - If the ack is 0 (arbiter served a register access or the other port), the pulse is reissued the following cycle. Retries are unlimited.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch op/addr/mask and go to RD_REQ. Increment cnt_insert or cnt_query.
  - RD_REQ: rd_req=1, rd_addr=addr; go to RD_ACK.
  - RD_ACK: rd_ack=1 → RD_WAIT (clear timeout counter); else → RD_REQ.
  - RD_WAIT: on rd_vld:
    - Compute hit = ((rd_data & mask) == mask).
    - If QUERY, or INSERT with hit: → DONE.
    - Else: latch wr_data = rd_data | mask; → WR_REQ.
    - If the timeout counter reaches RD_TIMEOUT without rd_vld: → DONE with err=1.
  - WR_REQ: wr_req=1, wr_addr=addr, wr_data held; → WR_ACK.
  - WR_ACK: wr_ack=1 → DONE; else → WR_REQ.
  - DONE: res_valid=1 for exactly one cycle with res_hit/res_err; increment cnt_hit if hit and not err; → IDLE.
- Nominal latencies (no contention, from IDLE accept at cycle 0):
  - rd_req at 1, rd_ack at 2, rd_vld at 5.
  - QUERY or INSERT-hit: res_valid at 6.
  - INSERT miss: wr_req at 6, wr_ack at 7, res_valid at 8.
- res_hit is 0 whenever res_err is 1.
- wr_addr/rd_addr/wr_data hold their values outside request pulses.
- Ordering: one command in flight, so a read-after-write to the same address is always coherent.
- Mask 0: always hit; INSERT performs no write.

Decomposition:
- Shared package sram_bf_pkg holds:
  - FSM state encoding: IDLE, RD_REQ, RD_ACK, RD_WAIT, WR_REQ, WR_ACK, DONE.
  - Op constants OP_QUERY=0, OP_INSERT=1.
  - Default widths 19/72.
- One sub-module is natural: sram_req_pulser, a generic pulse/ack-check/retry helper instantiated twice, once for the read port and once for the write port.
- Counters stay inline.

Test Plan:
- QUERY addr 0x00010, mask 0x1, SRAM word 0x0, no contention → rd_req pulse cycle 1; res_valid cycle 6 with hit=0; no wr_req; cnt_query=1.
- INSERT addr 0x00010, mask 0x80_0000_0000_0000_0001 onto word 0x0 → wr_req once with wr_data=mask; res_valid cycle 8 with hit=0. A following QUERY with the same mask returns hit=1 and cnt_hit=1.
- INSERT onto word already 0xFF..FF, mask 0x3 → no wr_req; res_valid cycle 6 with hit=1.
- Arbiter withholds rd_ack twice (register-access contention) → rd_req pulses three times, each separated by an idle cycle. Exactly one read is issued; the result is correct.
- rd_vld never arrives → res_valid with err=1, hit=0 at RD_TIMEOUT+3 cycles after accept; block returns to IDLE and accepts the next command.
- Reset asserted during RD_WAIT, stale rd_vld delivered after reset → no res_valid; all outputs hold reset values; cmd_ready=1.

Source files
------------

// File: rtl/sram_bf_pkg.sv
// Shared types and constants for the Bloom-filter SRAM read-modify-write client.
package sram_bf_pkg;

  localparam int DEF_ADDR_WIDTH = 19;
  localparam int DEF_DATA_WIDTH = 72;
  localparam int DEF_RD_TIMEOUT = 15;
  localparam int DEF_CNT_WIDTH  = 32;

  localparam logic OP_QUERY  = 1'b0;
  localparam logic OP_INSERT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_ACK  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WR_REQ  = 3'd4,
    S_WR_ACK  = 3'd5,
    S_DONE    = 3'd6
  } bf_state_t;

endpackage

// File: rtl/sram_req_pulser.sv
// Single-cycle request pulse generator with ack check one cycle later and unlimited retry.
// The arbiter latches req on sight, so req must never be high during its ack cycle.
module sram_req_pulser
  import sram_bf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_ack,
  output logic                  o_req,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_acked
);

  logic                  r_req;
  logic                  r_chk;
  logic [ADDR_WIDTH-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req  <= 1'b0;
      r_chk  <= 1'b0;
      r_addr <= '0;
    end else begin
      // a missed ack re-fires the pulse on the very next cycle
      r_req <= i_start | (r_chk & ~i_ack);
      r_chk <= r_req;
      if (i_start) begin
        r_addr <= i_addr;
      end
    end
  end

  assign o_req   = r_req;
  assign o_addr  = r_addr;
  assign o_acked = r_chk & i_ack;

endmodule

// File: rtl/sram_bf_rmw.sv
// Bloom-filter read-modify-write client in front of the SRAM arbiter requester port.
//   state   | meaning
//   IDLE    | cmd_ready high, waiting for a command
//   RD_REQ  | rd_req pulse on the bus
//   RD_ACK  | sample rd_ack, retry on miss
//   RD_WAIT | wait for rd_vld, bounded by RD_TIMEOUT
//   WR_REQ  | wr_req pulse with merged word
//   WR_ACK  | sample wr_ack, retry on miss
//   DONE    | one-cycle result pulse
module sram_bf_rmw
  import sram_bf_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SRAM_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_TIMEOUT      = DEF_RD_TIMEOUT,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_insert,
  input  logic [SRAM_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] cmd_mask,
  output logic                       res_valid,
  output logic                       res_hit,
  output logic                       res_err,
  output logic                       wr_req,
  output logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [SRAM_DATA_WIDTH-1:0] wr_data,
  input  logic                       wr_ack,
  output logic                       rd_req,
  output logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
  input  logic                       rd_ack,
  input  logic                       rd_vld,
  input  logic [SRAM_DATA_WIDTH-1:0] rd_data,
  output logic [CNT_WIDTH-1:0]       cnt_insert,
  output logic [CNT_WIDTH-1:0]       cnt_query,
  output logic [CNT_WIDTH-1:0]       cnt_hit
);

  localparam int TMO_WIDTH = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  bf_state_t                  r_state;
  logic                       r_cmd_ready;
  logic                       r_res_valid;
  logic                       r_res_hit;
  logic                       r_res_err;
  logic                       r_op;
  logic [SRAM_ADDR_WIDTH-1:0] r_addr;
  logic [SRAM_DATA_WIDTH-1:0] r_mask;
  logic [SRAM_DATA_WIDTH-1:0] r_wr_data;
  logic [TMO_WIDTH-1:0]       r_tmo;
  logic [CNT_WIDTH-1:0]       r_cnt_insert;
  logic [CNT_WIDTH-1:0]       r_cnt_query;
  logic [CNT_WIDTH-1:0]       r_cnt_hit;

  logic w_hit;
  logic w_rd_start;
  logic w_wr_start;
  logic w_rd_acked;
  logic w_wr_acked;

  assign w_hit      = ((rd_data & r_mask) == r_mask);
  assign w_rd_start = (r_state == S_IDLE) & cmd_valid;
  assign w_wr_start = (r_state == S_RD_WAIT) & rd_vld & (r_op == OP_INSERT) & ~w_hit;

  sram_req_pulser #(.ADDR_WIDTH(SRAM_ADDR_WIDTH)) u_rd_pulser (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_rd_start),
    .i_addr  (cmd_addr),
    .i_ack   (rd_ack),
    .o_req   (rd_req),
    .o_addr  (rd_addr),
    .o_acked (w_rd_acked)
  );

  sram_req_pulser #(.ADDR_WIDTH(SRAM_ADDR_WIDTH)) u_wr_pulser (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_wr_start),
    .i_addr  (r_addr),
    .i_ack   (wr_ack),
    .o_req   (wr_req),
    .o_addr  (wr_addr),
    .o_acked (w_wr_acked)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_hit    <= 1'b0;
      r_res_err    <= 1'b0;
      r_op         <= OP_QUERY;
      r_addr       <= '0;
      r_mask       <= '0;
      r_wr_data    <= '0;
      r_tmo        <= '0;
      r_cnt_insert <= '0;
      r_cnt_query  <= '0;
      r_cnt_hit    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op        <= cmd_insert;
            r_addr      <= cmd_addr;
            r_mask      <= cmd_mask;
            r_cmd_ready <= 1'b0;
            if (cmd_insert == OP_INSERT) r_cnt_insert <= r_cnt_insert + 1'b1;
            else                         r_cnt_query  <= r_cnt_query + 1'b1;
            r_state <= S_RD_REQ;
          end
        end
        S_RD_REQ: r_state <= S_RD_ACK;
        S_RD_ACK: begin
          if (w_rd_acked) begin
            r_tmo   <= TMO_WIDTH'(RD_TIMEOUT - 1);
            r_state <= S_RD_WAIT;
          end else begin
            r_state <= S_RD_REQ;
          end
        end
        S_RD_WAIT: begin
          // data arriving on the terminal-count cycle still counts as in time
          if (rd_vld) begin
            if ((r_op == OP_QUERY) || w_hit) begin
              r_res_valid <= 1'b1;
              r_res_hit   <= w_hit;
              r_res_err   <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_wr_data <= rd_data | r_mask;
              r_state   <= S_WR_REQ;
            end
          end else if (r_tmo == '0) begin
            r_res_valid <= 1'b1;
            r_res_hit   <= 1'b0;
            r_res_err   <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end
        S_WR_REQ: r_state <= S_WR_ACK;
        S_WR_ACK: begin
          if (w_wr_acked) begin
            r_res_valid <= 1'b1;
            r_res_hit   <= 1'b0;
            r_res_err   <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_WR_REQ;
          end
        end
        S_DONE: begin
          if (r_res_hit & ~r_res_err) r_cnt_hit <= r_cnt_hit + 1'b1;
          r_res_valid <= 1'b0;
          r_res_hit   <= 1'b0;
          r_res_err   <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign res_valid  = r_res_valid;
  assign res_hit    = r_res_hit;
  assign res_err    = r_res_err;
  assign wr_data    = r_wr_data;
  assign cnt_insert = r_cnt_insert;
  assign cnt_query  = r_cnt_query;
  assign cnt_hit    = r_cnt_hit;

endmodule

// File: tb/tb_sram_bf_rmw.sv
// Directed bench for sram_bf_rmw: vector table plus retry, timeout and reset sequences.
module tb_sram_bf_rmw;

  localparam int AW = 19;
  localparam int DW = 72;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_insert;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_mask;
  logic          res_valid, res_hit, res_err;
  logic          wr_req, wr_ack, rd_req, rd_ack, rd_vld;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [CW-1:0] cnt_insert, cnt_query, cnt_hit;

  sram_bf_rmw dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_insert(cmd_insert),
    .cmd_addr(cmd_addr), .cmd_mask(cmd_mask),
    .res_valid(res_valid), .res_hit(res_hit), .res_err(res_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_vld(rd_vld), .rd_data(rd_data),
    .cnt_insert(cnt_insert), .cnt_query(cnt_query), .cnt_hit(cnt_hit)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] mem [int];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return '0;
  endfunction

  // results of the last run_cmd
  int            o_res_cyc, o_rd_cnt, o_rd_acked, o_wr_cnt;
  logic          o_hit, o_err, o_gap_bad, o_addr_bad;
  logic [DW-1:0] o_wdata;
  int            exp_ins = 0, exp_q = 0, exp_hits = 0;

  task automatic run_cmd(input logic ins, input logic [AW-1:0] a, input logic [DW-1:0] m,
                         input int nack_rd, input int nack_wr, input bit drop_vld);
    int ack_rd_at, vld_at, ack_wr_at, last_rd;
    ack_rd_at = -1; vld_at = -1; ack_wr_at = -1; last_rd = -10;
    o_res_cyc = -1; o_rd_cnt = 0; o_rd_acked = 0; o_wr_cnt = 0;
    o_hit = 1'bx; o_err = 1'bx; o_gap_bad = 1'b0; o_addr_bad = 1'b0; o_wdata = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_insert = ins; cmd_addr = a; cmd_mask = m;
    for (int cyc = 0; cyc < 40 && o_res_cyc < 0; cyc++) begin
      @(negedge clk);
      if (rd_req) begin
        if (cyc - last_rd < 2) o_gap_bad = 1'b1;
        last_rd = cyc;
        o_rd_cnt++;
        if (rd_addr !== a) o_addr_bad = 1'b1;
        if (o_rd_cnt > nack_rd) begin
          ack_rd_at = cyc + 1;
          vld_at    = drop_vld ? -1 : cyc + 4;
          o_rd_acked++;
        end
      end
      if (wr_req) begin
        o_wr_cnt++;
        o_wdata = wr_data;
        if (wr_addr !== a) o_addr_bad = 1'b1;
        if (o_wr_cnt > nack_wr) begin
          ack_wr_at = cyc + 1;
          mem[int'(a)] = wr_data;
        end
      end
      if (res_valid) begin
        o_res_cyc = cyc; o_hit = res_hit; o_err = res_err;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      rd_ack  = (cyc + 1 == ack_rd_at);
      wr_ack  = (cyc + 1 == ack_wr_at);
      rd_vld  = (cyc + 1 == vld_at);
      rd_data = rd_vld ? mem_rd(a) : '0;
    end
  endtask

  typedef struct {
    logic          ins;
    logic [AW-1:0] addr;
    logic [DW-1:0] mask;
    bit            preset;
    logic [DW-1:0] word;
    logic          exp_hit;
    int            exp_wr;
    logic [DW-1:0] exp_wdata;
    int            exp_res;
  } vec_t;

  vec_t vecs [7];

  task automatic check_counters(input string tag);
    chk({tag, " cnt_insert"}, DW'(cnt_insert), DW'(exp_ins));
    chk({tag, " cnt_query"},  DW'(cnt_query),  DW'(exp_q));
    chk({tag, " cnt_hit"},    DW'(cnt_hit),    DW'(exp_hits));
  endtask

  initial begin
    vecs[0] = '{1'b0, 19'h00010, 72'h1, 1'b0, '0, 1'b0, 0, '0, 6};
    vecs[1] = '{1'b1, 19'h00010, 72'h80_0000_0000_0000_0001, 1'b0, '0, 1'b0, 1,
                72'h80_0000_0000_0000_0001, 8};
    vecs[2] = '{1'b0, 19'h00010, 72'h80_0000_0000_0000_0001, 1'b0, '0, 1'b1, 0, '0, 6};
    vecs[3] = '{1'b1, 19'h0002A, 72'h3, 1'b1, {DW{1'b1}}, 1'b1, 0, '0, 6};
    vecs[4] = '{1'b1, 19'h7FFFF, 72'h0, 1'b0, '0, 1'b1, 0, '0, 6};
    vecs[5] = '{1'b0, 19'h00020, 72'h0F, 1'b1, 72'h0E, 1'b0, 0, '0, 6};
    vecs[6] = '{1'b1, 19'h00020, 72'hF0, 1'b0, '0, 1'b0, 1, 72'hFE, 8};

    reset = 1'b1; cmd_valid = 1'b0; cmd_insert = 1'b0; cmd_addr = '0; cmd_mask = '0;
    wr_ack = 1'b0; rd_ack = 1'b0; rd_vld = 1'b0; rd_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst cmd_ready", DW'(cmd_ready), 1);
    chk("rst res_valid", DW'(res_valid), 0);
    chk("rst rd_req",    DW'(rd_req),    0);
    chk("rst wr_req",    DW'(wr_req),    0);
    chk("rst rd_addr",   DW'(rd_addr),   0);
    chk("rst wr_data",   wr_data,        0);
    check_counters("rst");

    foreach (vecs[i]) begin
      if (vecs[i].preset) mem[int'(vecs[i].addr)] = vecs[i].word;
      run_cmd(vecs[i].ins, vecs[i].addr, vecs[i].mask, 0, 0, 1'b0);
      if (vecs[i].ins) exp_ins++; else exp_q++;
      if (vecs[i].exp_hit) exp_hits++;
      chk($sformatf("v%0d res_cyc", i), DW'(o_res_cyc), DW'(vecs[i].exp_res));
      chk($sformatf("v%0d hit", i),     DW'(o_hit),     DW'(vecs[i].exp_hit));
      chk($sformatf("v%0d err", i),     DW'(o_err),     0);
      chk($sformatf("v%0d wr_cnt", i),  DW'(o_wr_cnt),  DW'(vecs[i].exp_wr));
      if (vecs[i].exp_wr > 0) chk($sformatf("v%0d wr_data", i), o_wdata, vecs[i].exp_wdata);
      chk($sformatf("v%0d addr", i),    DW'(o_addr_bad), 0);
      check_counters($sformatf("v%0d", i));
    end

    // read ack withheld twice
    run_cmd(1'b0, 19'h00010, 72'h80_0000_0000_0000_0001, 2, 0, 1'b0);
    exp_q++; exp_hits++;
    chk("rdretry pulses",  DW'(o_rd_cnt),   3);
    chk("rdretry acked",   DW'(o_rd_acked), 1);
    chk("rdretry gap",     DW'(o_gap_bad),  0);
    chk("rdretry res_cyc", DW'(o_res_cyc),  10);
    chk("rdretry hit",     DW'(o_hit),      1);
    check_counters("rdretry");

    // write ack withheld once
    run_cmd(1'b1, 19'h00033, 72'h5, 0, 1, 1'b0);
    exp_ins++;
    chk("wrretry pulses",  DW'(o_wr_cnt),  2);
    chk("wrretry data",    o_wdata,        72'h5);
    chk("wrretry res_cyc", DW'(o_res_cyc), 10);
    chk("wrretry hit",     DW'(o_hit),     0);
    check_counters("wrretry");

    // rd_vld never arrives
    run_cmd(1'b0, 19'h00033, 72'h4, 0, 0, 1'b1);
    exp_q++;
    chk("tmo res_cyc", DW'(o_res_cyc), 18);
    chk("tmo err",     DW'(o_err),     1);
    chk("tmo hit",     DW'(o_hit),     0);
    check_counters("tmo");

    // next command after timeout sees the earlier write
    run_cmd(1'b0, 19'h00033, 72'h4, 0, 0, 1'b0);
    exp_q++; exp_hits++;
    chk("posttmo res_cyc", DW'(o_res_cyc), 6);
    chk("posttmo hit",     DW'(o_hit),     1);
    chk("posttmo err",     DW'(o_err),     0);
    check_counters("posttmo");

    // reset during RD_WAIT, stale rd_vld afterwards
    begin
      int res_seen, req_seen;
      res_seen = 0; req_seen = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_insert = 1'b1; cmd_addr = 19'h00055; cmd_mask = 72'h1;
      @(posedge clk); #1; cmd_valid = 1'b0;
      @(posedge clk); #1; rd_ack = 1'b1;
      @(posedge clk); #1; rd_ack = 1'b0; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0; rd_vld = 1'b1; rd_data = '0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (res_valid) res_seen++;
        if (rd_req || wr_req) req_seen++;
        @(posedge clk); #1; rd_vld = 1'b0;
      end
      exp_ins = 0; exp_q = 0; exp_hits = 0;
      chk("rstmid res_valid", DW'(res_seen),  0);
      chk("rstmid requests",  DW'(req_seen),  0);
      chk("rstmid cmd_ready", DW'(cmd_ready), 1);
      chk("rstmid res_err",   DW'(res_err),   0);
      chk("rstmid rd_addr",   DW'(rd_addr),   0);
      check_counters("rstmid");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
